// File: rtl/dram_fifo_cmd_arbiter.sv
// dram_fifo_cmd_arbiter: schedules per-channel write/read burst commands from the DRAM FIFO
// channels onto one shared AXI4 AW/AR port, with direction batching, round-robin and drain.
`default_nettype none

module dram_fifo_cmd_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 8,
  parameter int MAX_OUTST = 4,
  parameter int BATCH     = 4
) (
  input  logic                     bus_clk,
  input  logic                     bus_rst_n,
  input  logic                     clear,
  input  logic                     calib_done,
  input  logic [NUM_CH-1:0]        wr_req,
  input  logic [NUM_CH*ADDR_W-1:0] wr_addr,
  input  logic [NUM_CH*LEN_W-1:0]  wr_len,
  output logic [NUM_CH-1:0]        wr_gnt,
  input  logic [NUM_CH-1:0]        rd_req,
  input  logic [NUM_CH*ADDR_W-1:0] rd_addr,
  input  logic [NUM_CH*LEN_W-1:0]  rd_len,
  output logic [NUM_CH-1:0]        rd_gnt,
  output logic [2:0]               m_axi_awid,
  output logic [ADDR_W-1:0]        m_axi_awaddr,
  output logic [LEN_W-1:0]         m_axi_awlen,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [2:0]               m_axi_arid,
  output logic [ADDR_W-1:0]        m_axi_araddr,
  output logic [LEN_W-1:0]         m_axi_arlen,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic                     rd_last_done,
  output logic                     drain_done,
  output logic                     busy
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int BC_W  = $clog2(BATCH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTST);
  localparam logic [BC_W-1:0]  BATCH_MAX = BC_W'(BATCH);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE_W, S_ISSUE_R, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wr_cnt, rd_cnt;
  logic [BC_W-1:0]   batch_cnt;
  logic              last_wr;
  logic [CH_W-1:0]   wr_start, rd_start;
  logic [CH_W-1:0]   wr_ch, rd_ch, aw_ch, ar_ch;
  logic              wr_elig, rd_elig, pick_wr, do_issue;
  logic              aw_hs, ar_hs, wr_dec, rd_dec;

  logic [ADDR_W-1:0] wr_addr_a [NUM_CH];
  logic [ADDR_W-1:0] rd_addr_a [NUM_CH];
  logic [LEN_W-1:0]  wr_len_a  [NUM_CH];
  logic [LEN_W-1:0]  rd_len_a  [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign wr_addr_a[g] = wr_addr[g*ADDR_W +: ADDR_W];
    assign rd_addr_a[g] = rd_addr[g*ADDR_W +: ADDR_W];
    assign wr_len_a[g]  = wr_len[g*LEN_W +: LEN_W];
    assign rd_len_a[g]  = rd_len[g*LEN_W +: LEN_W];
  end

  // First requesting channel at or after start; start holds "last granted + 1".
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   start);
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] res;
    res = start;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      sum = {1'b0, start} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      if (req[sum[CH_W-1:0]]) res = sum[CH_W-1:0];
    end
    return res;
  endfunction

  assign wr_ch = rr_pick(wr_req, wr_start);
  assign rd_ch = rr_pick(rd_req, rd_start);
  assign aw_ch = m_axi_awid[CH_W-1:0];
  assign ar_ch = m_axi_arid[CH_W-1:0];

  assign m_axi_awvalid = (state == S_ISSUE_W);
  assign m_axi_arvalid = (state == S_ISSUE_R);
  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign ar_hs  = m_axi_arvalid && m_axi_arready;
  assign wr_dec = m_axi_bvalid && (wr_cnt != '0);
  assign rd_dec = rd_last_done && (rd_cnt != '0);

  always_comb begin
    wr_elig = calib_done && !clear && (|wr_req) && (wr_cnt < CNT_MAX);
    rd_elig = calib_done && !clear && (|rd_req) && (rd_cnt < CNT_MAX);
    if (wr_elig && rd_elig) pick_wr = last_wr ? (batch_cnt < BATCH_MAX) : (batch_cnt >= BATCH_MAX);
    else                    pick_wr = wr_elig;
    do_issue = (state == S_IDLE) && !clear && (wr_elig || rd_elig);
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (clear)         state_nxt = S_DRAIN;
        else if (do_issue) state_nxt = pick_wr ? S_ISSUE_W : S_ISSUE_R;
      end
      S_ISSUE_W: if (m_axi_awready) state_nxt = clear ? S_DRAIN : S_IDLE;
      S_ISSUE_R: if (m_axi_arready) state_nxt = clear ? S_DRAIN : S_IDLE;
      S_DRAIN:   if (!clear)        state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wr_gnt = '0;
    rd_gnt = '0;
    if (aw_hs) wr_gnt[aw_ch] = 1'b1;
    if (ar_hs) rd_gnt[ar_ch] = 1'b1;
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      m_axi_awid   <= '0;
      m_axi_awaddr <= '0;
      m_axi_awlen  <= '0;
      m_axi_arid   <= '0;
      m_axi_araddr <= '0;
      m_axi_arlen  <= '0;
      m_axi_bready <= 1'b0;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      batch_cnt    <= '0;
      last_wr      <= 1'b1;
      wr_start     <= '0;
      rd_start     <= '0;
    end else begin
      m_axi_bready <= 1'b1;
      if (do_issue) begin
        if (pick_wr) begin
          m_axi_awid   <= 3'(wr_ch);
          m_axi_awaddr <= wr_addr_a[wr_ch];
          m_axi_awlen  <= wr_len_a[wr_ch];
        end else begin
          m_axi_arid   <= 3'(rd_ch);
          m_axi_araddr <= rd_addr_a[rd_ch];
          m_axi_arlen  <= rd_len_a[rd_ch];
        end
        if (pick_wr == last_wr) begin
          if (batch_cnt < BATCH_MAX) batch_cnt <= batch_cnt + 1'b1;
        end else begin
          batch_cnt <= BC_W'(1);
          last_wr   <= pick_wr;
        end
      end
      if (aw_hs) wr_start <= (aw_ch == LAST_CH) ? '0 : aw_ch + 1'b1;
      if (ar_hs) rd_start <= (ar_ch == LAST_CH) ? '0 : ar_ch + 1'b1;
      case ({aw_hs, wr_dec})
        2'b10:   wr_cnt <= wr_cnt + 1'b1;
        2'b01:   wr_cnt <= wr_cnt - 1'b1;
        default: wr_cnt <= wr_cnt;
      endcase
      case ({ar_hs, rd_dec})
        2'b10:   rd_cnt <= rd_cnt + 1'b1;
        2'b01:   rd_cnt <= rd_cnt - 1'b1;
        default: rd_cnt <= rd_cnt;
      endcase
    end
  end

  assign drain_done = clear && !m_axi_awvalid && !m_axi_arvalid && (wr_cnt == '0) && (rd_cnt == '0);
  assign busy       = m_axi_awvalid || m_axi_arvalid || (wr_cnt != '0) || (rd_cnt != '0);

  // A response with nothing outstanding is a protocol error upstream.
  a_wr_underflow: assert property (@(posedge bus_clk) disable iff (!bus_rst_n)
                                   !(m_axi_bvalid && wr_cnt == '0));
  a_rd_underflow: assert property (@(posedge bus_clk) disable iff (!bus_rst_n)
                                   !(rd_last_done && rd_cnt == '0));

endmodule

`default_nettype wire

// File: tb/tb_dram_fifo_cmd_arbiter.sv
// tb_dram_fifo_cmd_arbiter: directed self-checking bench for dram_fifo_cmd_arbiter.
`default_nettype none

module tb_dram_fifo_cmd_arbiter;
  logic        clk = 1'b0;
  logic        rst_n, clear, calib_done;
  logic [1:0]  wr_req, rd_req, wr_gnt, rd_gnt;
  logic [63:0] wr_addr, rd_addr;
  logic [15:0] wr_len, rd_len;
  logic [2:0]  awid, arid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, bvalid, bready, arvalid, arready, rd_last_done;
  logic        drain_done, busy;

  int vectors = 0;
  int miscompares = 0;
  int bad;
  int wn, rn;
  logic [8:0] dirs;
  logic [2:0] ech;

  always #5 clk = ~clk;

  dram_fifo_cmd_arbiter dut (
    .bus_clk(clk), .bus_rst_n(rst_n), .clear(clear), .calib_done(calib_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_gnt(rd_gnt),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .rd_last_done(rd_last_done), .drain_done(drain_done), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; calib_done = 1'b0;
    wr_req = '0; rd_req = '0; awready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; rd_last_done = 1'b0;
    wr_addr = {32'h2000_0000, 32'h1000_0000};
    wr_len  = {8'h1F, 8'h0F};
    rd_addr = {32'h4000_0000, 32'h3000_0000};
    rd_len  = {8'h07, 8'h03};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_wr_gnt", wr_gnt, 0);
    rst_n = 1'b1;
    cyc();
    chk("bready_after_rst", bready, 1);

    // no command while uncalibrated
    wr_req = 2'b11;
    bad = 0;
    repeat (50) begin
      cyc();
      if (awvalid || arvalid) bad++;
    end
    chk("calib_gate", bad, 0);
    calib_done = 1'b1;
    cyc();
    chk("calib_awvalid", awvalid, 1);
    chk("calib_awid", awid, 0);
    chk("calib_awaddr", awaddr, 32'h1000_0000);
    chk("calib_awlen", awlen, 8'h0F);

    // backpressure with the request withdrawn
    wr_req = 2'b00;
    bad = 0;
    repeat (10) begin
      cyc();
      if (awvalid !== 1'b1 || awaddr !== 32'h1000_0000 || awlen !== 8'h0F || awid !== 3'd0) bad++;
    end
    chk("bp_stable", bad, 0);
    awready = 1'b1;
    #1;
    chk("bp_wr_gnt", wr_gnt, 2'b01);
    cyc();
    chk("bp_awvalid_drop", awvalid, 0);
    chk("bp_wr_gnt_drop", wr_gnt, 0);
    chk("bp_busy", busy, 1);
    bvalid = 1'b1;
    cyc();
    bvalid = 1'b0;
    chk("bp_busy_clear", busy, 0);

    // round-robin: last grant was ch0, so ch1 first; cap of 4 outstanding
    wr_req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ech = (k % 2 == 0) ? 3'd1 : 3'd0;
      cyc();
      chk("rr_awvalid", awvalid, 1);
      chk("rr_awid", awid, ech);
      chk("rr_wr_gnt", wr_gnt, 64'(1) << ech);
      chk("rr_awaddr", awaddr, (ech == 3'd1) ? 32'h2000_0000 : 32'h1000_0000);
      cyc();
      chk("rr_gap", awvalid, 0);
    end
    bad = 0;
    repeat (5) begin
      cyc();
      if (awvalid || wr_gnt != 2'b00) bad++;
    end
    chk("outst_stall", bad, 0);
    bvalid = 1'b1;
    cyc();
    bvalid = 1'b0;
    chk("outst_bvalid_edge", awvalid, 0);
    cyc();
    chk("outst_extra_awvalid", awvalid, 1);
    chk("outst_extra_awid", awid, 1);
    cyc();
    bad = 0;
    repeat (4) begin
      cyc();
      if (awvalid) bad++;
    end
    chk("outst_stall2", bad, 0);
    wr_req = 2'b00;
    bvalid = 1'b1;
    repeat (4) cyc();
    bvalid = 1'b0;
    chk("outst_drained", busy, 0);

    // batching: writes hold a full batch, so reads go first
    wr_req = 2'b11; rd_req = 2'b11; arready = 1'b1;
    dirs = 9'b1_0000_1111;
    wn = 0; rn = 0;
    for (int k = 0; k < 9; k++) begin
      cyc();
      bvalid = 1'b0; rd_last_done = 1'b0;
      if (dirs[k]) begin
        ech = 3'(rn % 2);
        chk("batch_arvalid", arvalid, 1);
        chk("batch_awvalid_idle", awvalid, 0);
        chk("batch_arid", arid, ech);
        chk("batch_araddr", araddr, (ech == 3'd1) ? 32'h4000_0000 : 32'h3000_0000);
        chk("batch_rd_gnt", rd_gnt, 64'(1) << ech);
        rn++;
      end else begin
        ech = 3'(wn % 2);
        chk("batch_awvalid", awvalid, 1);
        chk("batch_arvalid_idle", arvalid, 0);
        chk("batch_awid", awid, ech);
        chk("batch_wr_gnt", wr_gnt, 64'(1) << ech);
        wn++;
      end
      cyc();
      if (dirs[k]) rd_last_done = 1'b1;
      else         bvalid = 1'b1;
      if (k == 8) begin
        wr_req = 2'b00; rd_req = 2'b00;
      end
    end
    cyc();
    bvalid = 1'b0; rd_last_done = 1'b0;
    chk("batch_idle", busy, 0);

    // drain: 3 writes and 2 reads outstanding
    wr_req = 2'b01;
    repeat (6) cyc();
    wr_req = 2'b00; rd_req = 2'b10;
    cyc();
    chk("drain_setup_arid", arid, 1);
    repeat (3) cyc();
    rd_req = 2'b00;
    clear = 1'b1; wr_req = 2'b11; rd_req = 2'b11;
    bad = 0;
    repeat (5) begin
      cyc();
      if (awvalid || arvalid || wr_gnt != 2'b00 || rd_gnt != 2'b00 || drain_done) bad++;
    end
    chk("drain_blocked", bad, 0);
    chk("drain_busy", busy, 1);
    bvalid = 1'b1;
    repeat (3) cyc();
    bvalid = 1'b0;
    chk("drain_wr_done_only", drain_done, 0);
    rd_last_done = 1'b1;
    cyc();
    chk("drain_rd_pending", drain_done, 0);
    cyc();
    rd_last_done = 1'b0;
    chk("drain_done_rise", drain_done, 1);
    chk("drain_busy_clear", busy, 0);
    clear = 1'b0;
    #1;
    chk("drain_done_fall", drain_done, 0);

    // resume: reads hold the batch (2 < 4), read pointer wraps to ch0
    arready = 1'b0;
    cyc();
    chk("resume_exit_drain", arvalid, 0);
    cyc();
    chk("resume_arvalid", arvalid, 1);
    chk("resume_arid", arid, 0);
    chk("resume_araddr", araddr, 32'h3000_0000);
    chk("resume_arlen", arlen, 8'h03);
    chk("resume_awvalid", awvalid, 0);

    // asynchronous reset in the middle of a pending command
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_arvalid", arvalid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_bready", bready, 0);
    wr_req = 2'b00; rd_req = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
